// File: rtl/int_controller_pkg.sv
// Shared constants and helpers for the interrupt controller: register map,
// source count, VECTOR layout and the byte-lane commit type.
package int_controller_pkg;

  localparam int INT_NUM_SRC = 7;

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_MASK    = 2'd1;
  localparam logic [1:0] REG_CONFIG  = 2'd2;
  localparam logic [1:0] REG_VECTOR  = 2'd3;

  localparam int VEC_VALID_BIT = 15;
  localparam int ROUTE_LSB     = 8;

  typedef struct packed {
    logic hi;
    logic lo;
  } lane_t;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/int_sync_edge.sv
// Per-source 2-flop synchroniser plus a third flop for rising-edge detection.
module int_sync_edge (
  input  logic CLK,
  input  logic RESETN,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;

endmodule

// File: rtl/int_controller.sv
// Seven-source interrupt controller: edge/level capture, mask, two-way routing,
// priority VECTOR and one-shot byte-lane register writes.
module int_controller
  import int_controller_pkg::*;
#(
  parameter int NUM_SRC = INT_NUM_SRC
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic [NUM_SRC-1:0] INTS,
  input  logic               SEL,
  input  logic [1:0]         REG,
  input  logic [15:0]        WDATA,
  input  logic               RDN,
  input  logic               WR0N,
  input  logic               WR1N,
  output logic [15:0]        RDATA,
  output logic               INT0,
  output logic               INT1
);

  logic [NUM_SRC-1:0] sync_level, sync_rise;
  logic [NUM_SRC-1:0] pending, mask, mode, route;
  logic [NUM_SRC-1:0] w1c, active, act_hi, act_lo;
  logic               wr0_q, wr1_q, wr_armed;
  lane_t              commit;
  logic [15:0]        vector, config_rd;
  logic               unused_wdata;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    int_sync_edge u_sync (
      .CLK   (CLK),
      .RESETN(RESETN),
      .raw   (INTS[i]),
      .level (sync_level[i]),
      .rise  (sync_rise[i])
    );
  end

  // wr_armed blocks a strobe that was already low when reset released.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      wr0_q    <= 1'b1;
      wr1_q    <= 1'b1;
      wr_armed <= 1'b0;
    end else begin
      wr0_q    <= WR0N;
      wr1_q    <= WR1N;
      wr_armed <= 1'b1;
    end
  end

  always_comb begin
    commit.lo = SEL & ~WR0N & wr0_q & wr_armed;
    commit.hi = SEL & ~WR1N & wr1_q & wr_armed;
  end

  assign w1c = (commit.lo && REG == REG_PENDING) ? WDATA[NUM_SRC-1:0] : '0;

  // Edge sources latch until W1C (a same-cycle set wins); level sources follow.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      pending <= '0;
    end else begin
      pending <= (mode & (sync_rise | (pending & ~w1c))) | (~mode & sync_level);
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      mask  <= '0;
      mode  <= '0;
      route <= '0;
    end else begin
      if (commit.lo && REG == REG_MASK)   mask  <= WDATA[NUM_SRC-1:0];
      if (commit.lo && REG == REG_CONFIG) mode  <= WDATA[NUM_SRC-1:0];
      if (commit.hi && REG == REG_CONFIG) route <= WDATA[ROUTE_LSB +: NUM_SRC];
    end
  end

  assign unused_wdata = ^WDATA;

  assign active = pending & mask;
  assign act_hi = active & route;
  assign act_lo = active & ~route;

  always_comb begin
    vector = '0;
    if (|act_hi) begin
      vector[VEC_VALID_BIT] = 1'b1;
      vector[2:0]           = lowest_set(8'(act_hi));
    end else if (|act_lo) begin
      vector[VEC_VALID_BIT] = 1'b1;
      vector[2:0]           = lowest_set(8'(act_lo));
    end
  end

  always_comb begin
    config_rd                         = '0;
    config_rd[NUM_SRC-1:0]            = mode;
    config_rd[ROUTE_LSB +: NUM_SRC]   = route;
  end

  always_comb begin
    RDATA = '0;
    if (SEL && !RDN) begin
      case (REG)
        REG_PENDING: RDATA = 16'(pending);
        REG_MASK:    RDATA = 16'(mask);
        REG_CONFIG:  RDATA = config_rd;
        REG_VECTOR:  RDATA = vector;
        default:     RDATA = '0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      INT0 <= 1'b0;
      INT1 <= 1'b0;
    end else begin
      INT0 <= |act_hi;
      INT1 <= |act_lo;
    end
  end

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller; inputs change and outputs are sampled on
// the falling clock edge, away from the rising edge the DUT uses.
module tb_int_controller;
  import int_controller_pkg::*;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic [6:0]  INTS;
  logic        SEL, RDN, WR0N, WR1N;
  logic [1:0]  REG;
  logic [15:0] WDATA, RDATA;
  logic        INT0, INT1;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_q[$];

  always #5 CLK = ~CLK;

  int_controller #(.NUM_SRC(7)) dut (
    .CLK   (CLK),
    .RESETN(RESETN),
    .INTS  (INTS),
    .SEL   (SEL),
    .REG   (REG),
    .WDATA (WDATA),
    .RDN   (RDN),
    .WR0N  (WR0N),
    .WR1N  (WR1N),
    .RDATA (RDATA),
    .INT0  (INT0),
    .INT1  (INT1)
  );

  task automatic idle();
    SEL = 1'b0; RDN = 1'b1; WR0N = 1'b1; WR1N = 1'b1; REG = 2'd0; WDATA = 16'h0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset();
    idle();
    INTS = '0;
    RESETN = 1'b0;
    cycles(2);
    RESETN = 1'b1;
    cycles(1);
  endtask

  // Strobes low for one rising edge, then high for one more so the next write re-arms.
  task automatic wr(input logic [1:0] r, input logic [15:0] d, input logic lo, input logic hi);
    SEL = 1'b1; REG = r; WDATA = d; WR0N = ~lo; WR1N = ~hi;
    @(negedge CLK);
    WR0N = 1'b1; WR1N = 1'b1; SEL = 1'b0;
    @(negedge CLK);
  endtask

  task automatic rd(input logic [1:0] r, output logic [15:0] d);
    SEL = 1'b1; REG = r; RDN = 1'b0;
    #1;
    d = RDATA;
    RDN = 1'b1; SEL = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] got, e;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      exp_q.push_back(16'h0000);
      rd(2'(r), got);
      e = exp_q.pop_front();
      tests++;
      if (got !== e) begin fails++; $display("FAIL reset_read reg%0d: got %h exp %h", r, got, e); end
    end
    tests++;
    if ({INT0, INT1} !== 2'b00) begin fails++; $display("FAIL reset_ints: got %b exp 00", {INT0, INT1}); end
    SEL = 1'b1; REG = REG_MASK; RDN = 1'b1; WDATA = 16'h0;
    wr(REG_MASK, 16'h0055, 1'b1, 1'b0);
    SEL = 1'b1; REG = REG_MASK; #1;
    tests++;
    if (RDATA !== 16'h0000) begin fails++; $display("FAIL rdn_high_read: got %h exp 0000", RDATA); end
    SEL = 1'b0;
  endtask

  task automatic test_edge();
    logic [15:0] got, e;
    do_reset();
    wr(REG_MASK, 16'h0004, 1'b1, 1'b0);
    wr(REG_CONFIG, 16'h0404, 1'b1, 1'b1);
    INTS[2] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLK);
      INTS[2] = 1'b0;
      tests++;
      if (INT0 !== 1'(i == 4)) begin fails++; $display("FAIL edge_latency cyc%0d: got %b exp %b", i, INT0, 1'(i == 4)); end
    end
    tests++;
    if (INT1 !== 1'b0) begin fails++; $display("FAIL edge_int1: got %b exp 0", INT1); end
    exp_q.push_back(16'h8002);
    rd(REG_VECTOR, got);
    e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL edge_vector: got %h exp %h", got, e); end
    SEL = 1'b1; REG = REG_PENDING; WDATA = 16'h0004; WR0N = 1'b0;
    @(negedge CLK);
    tests++;
    if (INT0 !== 1'b1) begin fails++; $display("FAIL w1c_commit_cycle: got %b exp 1", INT0); end
    WR0N = 1'b1; SEL = 1'b0;
    @(negedge CLK);
    tests++;
    if (INT0 !== 1'b0) begin fails++; $display("FAIL w1c_int0_drop: got %b exp 0", INT0); end
    exp_q.push_back(16'h0000);
    rd(REG_PENDING, got);
    e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL w1c_pending: got %h exp %h", got, e); end
  endtask

  task automatic test_level();
    logic [15:0] got, e;
    do_reset();
    wr(REG_MASK, 16'h0020, 1'b1, 1'b0);
    INTS[5] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLK);
      tests++;
      if (INT1 !== 1'(i == 4)) begin fails++; $display("FAIL level_rise cyc%0d: got %b exp %b", i, INT1, 1'(i == 4)); end
    end
    wr(REG_PENDING, 16'h0020, 1'b1, 1'b0);
    cycles(2);
    exp_q.push_back(16'h0020);
    rd(REG_PENDING, got);
    e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL level_w1c_ignored: got %h exp %h", got, e); end
    tests++;
    if (INT1 !== 1'b1) begin fails++; $display("FAIL level_int1_hold: got %b exp 1", INT1); end
    INTS[5] = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLK);
      tests++;
      if (INT1 !== 1'(i < 4)) begin fails++; $display("FAIL level_fall cyc%0d: got %b exp %b", i, INT1, 1'(i < 4)); end
    end
  endtask

  task automatic test_vector_priority();
    logic [15:0] got, e;
    do_reset();
    wr(REG_CONFIG, 16'h1012, 1'b1, 1'b1);
    wr(REG_MASK, 16'h0012, 1'b1, 1'b0);
    INTS = 7'h12;
    @(negedge CLK);
    INTS = '0;
    cycles(5);
    exp_q.push_back(16'h8004);
    rd(REG_VECTOR, got);
    e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL vector_int0_first: got %h exp %h", got, e); end
    tests++;
    if ({INT0, INT1} !== 2'b11) begin fails++; $display("FAIL vector_both_ints: got %b exp 11", {INT0, INT1}); end
    wr(REG_CONFIG, 16'h0012, 1'b1, 1'b1);
    exp_q.push_back(16'h8001);
    rd(REG_VECTOR, got);
    e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL vector_unrouted: got %h exp %h", got, e); end
    tests++;
    if ({INT0, INT1} !== 2'b01) begin fails++; $display("FAIL vector_reroute_ints: got %b exp 01", {INT0, INT1}); end
    wr(REG_MASK, 16'h0000, 1'b1, 1'b0);
    exp_q.push_back(16'h0000);
    rd(REG_VECTOR, got);
    e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL vector_masked: got %h exp %h", got, e); end
  endtask

  task automatic test_held_strobe();
    logic [15:0] got, e;
    do_reset();
    SEL = 1'b1; REG = REG_MASK; WDATA = 16'h007F; WR0N = 1'b0;
    @(negedge CLK);
    WDATA = 16'h0001;
    cycles(4);
    WR0N = 1'b1; SEL = 1'b0;
    @(negedge CLK);
    exp_q.push_back(16'h007F);
    rd(REG_MASK, got);
    e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL held_strobe_once: got %h exp %h", got, e); end
    wr(REG_MASK, 16'hFFFF, 1'b1, 1'b1);
    exp_q.push_back(16'h007F);
    rd(REG_MASK, got);
    e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL mask_unused_bits: got %h exp %h", got, e); end
    wr(REG_CONFIG, 16'hFFFF, 1'b1, 1'b1);
    wr(REG_CONFIG, 16'h0000, 1'b0, 1'b1);
    exp_q.push_back(16'h007F);
    rd(REG_CONFIG, got);
    e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL config_high_lane_only: got %h exp %h", got, e); end
  endtask

  task automatic test_collision_and_reset();
    logic [15:0] got, e;
    do_reset();
    wr(REG_MASK, 16'h0008, 1'b1, 1'b0);
    wr(REG_CONFIG, 16'h0008, 1'b1, 1'b1);
    INTS[3] = 1'b1;
    cycles(2);
    SEL = 1'b1; REG = REG_PENDING; WDATA = 16'h0008; WR0N = 1'b0;
    @(negedge CLK);
    WR0N = 1'b1; SEL = 1'b0;
    cycles(2);
    exp_q.push_back(16'h0008);
    rd(REG_PENDING, got);
    e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL set_beats_w1c: got %h exp %h", got, e); end
    tests++;
    if (INT1 !== 1'b1) begin fails++; $display("FAIL collision_int1: got %b exp 1", INT1); end
    // Reset lands mid-write with source 0 held high.
    INTS = 7'h01;
    SEL = 1'b1; REG = REG_MASK; WDATA = 16'h007F; WR0N = 1'b0;
    #2;
    RESETN = 1'b0;
    #1;
    tests++;
    if ({INT0, INT1} !== 2'b00) begin fails++; $display("FAIL async_reset_ints: got %b exp 00", {INT0, INT1}); end
    cycles(2);
    RESETN = 1'b1;
    cycles(3);
    WR0N = 1'b1; SEL = 1'b0;
    cycles(2);
    exp_q.push_back(16'h0000);
    rd(REG_MASK, got);
    e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL reset_held_strobe: got %h exp %h", got, e); end
    exp_q.push_back(16'h0001);
    rd(REG_PENDING, got);
    e = exp_q.pop_front(); tests++;
    if (got !== e) begin fails++; $display("FAIL reset_pending_src0: got %h exp %h", got, e); end
    tests++;
    if ({INT0, INT1} !== 2'b00) begin fails++; $display("FAIL reset_release_ints: got %b exp 00", {INT0, INT1}); end
  endtask

  initial begin
    RESETN = 1'b0;
    INTS = '0;
    idle();
    @(negedge CLK);
    test_reset();
    test_edge();
    test_level();
    test_vector_priority();
    test_held_strobe();
    test_collision_and_reset();
    tests++;
    if (exp_q.size() !== 0) begin fails++; $display("FAIL scoreboard_leftover: got %0d exp 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/int_controller.md
INT_CONTROLLER -- requirements
Module: int_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports CLK and RESETN.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK  in  1  system clock
- RESETN  in  1  async active-low reset
- INTS  in  7  raw interrupt sources 0..6, asynchronous to CLK
- SEL  in  1  register window selected (address decode done upstream)
- REG  in  2  register index
- WDATA  in  16  CPU write data
- RDN  in  1  read strobe, active low
- WR0N  in  1  low-byte write strobe, active low
- WR1N  in  1  high-byte write strobe, active low
- RDATA  out  16  read data
- INT0  out  1  high-priority CPU interrupt request
- INT1  out  1  low-priority CPU interrupt request
REQ-003 Parameter NUM_SRC SHALL default to 7 and gives the number of interrupt sources.

Function
REQ-004 Register map by REG:
- 0 PENDING: bits 6:0; read returns pending; write-1-to-clear.
- 1 MASK: bits 6:0; read/write; 1 = enabled.
- 2 CONFIG: bits 6:0 MODE (1 = edge, 0 = level); bits 14:8 ROUTE (1 = INT0, 0 = INT1).
- 3 VECTOR: read-only.
Unused bits SHALL read 0 and ignore writes.
REQ-005 Each INTS bit SHALL pass through a 2-flop synchroniser, then a third flop for rising-edge detection.
REQ-006 Edge mode: pending[i] SHALL set on the cycle the synchronised level rises, and hold until cleared by write-1.
REQ-007 Level mode: pending[i] SHALL equal the synchronised level delayed one cycle; write-1-to-clear has no effect.
REQ-008 If a set and a W1C hit the same bit in the same cycle, set SHALL win.
REQ-009 Writes SHALL be one-shot: a byte lane commits on the first CLK edge where SEL=1, its strobe is sampled low, and that strobe was sampled high on the previous edge. A held strobe SHALL NOT re-commit.
REQ-010 WR0N SHALL write bits 7:0 and WR1N bits 15:8; both strobes low together is a 16-bit write.
REQ-011 RDATA SHALL be combinational: the selected register when SEL=1 and RDN=0, else 16'h0000. Reads SHALL have no side effects.
REQ-012 VECTOR SHALL read as follows:
- bit 15 = 1 if any (pending & mask) bit is set; bits 2:0 = lowest-numbered such source.
- Lowest-numbered INT0-routed sources take precedence over INT1-routed ones.
- If none is set, VECTOR SHALL read 16'h0000.
REQ-013 INT0 and INT1 SHALL be registered outputs: INT0 = OR(pending & mask & ROUTE), INT1 = OR(pending & mask & ~ROUTE).
REQ-014 Edge-mode latency: an INTS rising edge first sampled at CLK edge k SHALL assert INT0/INT1 after edge k+3 (4 cycles), provided the source is enabled.
REQ-015 Clearing a pending bit or a mask bit SHALL deassert the corresponding INT one cycle after the commit edge.
REQ-016 Changing MODE from edge to level SHALL leave existing pending bits unchanged until the next level update. Changing MODE from level to edge SHALL hold the current pending value.

Reset
REQ-017 While RESETN=0, the following SHALL be cleared:
- synchroniser and edge flops
- PENDING, MASK, CONFIG
- write-strobe history (set to "high")
- INT0 and INT1 (both 0)
REQ-018 Reset SHALL take effect immediately (asynchronously). Release SHALL be used only at a CLK edge.
REQ-019 An edge-mode input held high across reset release SHALL be treated as a new rising edge and set pending. This is harmless because MASK=0 after reset.
REQ-020 A write strobe held low across reset release SHALL NOT commit.

Structure
REQ-021 Register indices, NUM_SRC and the VECTOR valid-bit position SHALL live in the shared constants file (constants.v).
REQ-022 One sub-module, int_sync_edge, SHALL implement per-source synchronisation and rising-edge detection, instantiated NUM_SRC times.
REQ-023 The block SHALL be instantiated inside testResources, consuming INTS0..6 and driving the core's INT0 and INT1.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset, then read all four registers -> every read returns 16'h0000; INT0=INT1=0.
- MASK=0x0004, ROUTE bit2=1, MODE bit2=1; pulse INTS[2] high for 1 cycle -> INT0=1 exactly 4 cycles later; VECTOR=0x8002; write PENDING=0x0004 -> INT0=0 one cycle after commit.
- Level mode on src 5, MASK=0x0020, ROUTE=0: hold INTS[5] high -> INT1=1; W1C has no effect; drop INTS[5] -> INT1 falls 4 cycles later.
- Srcs 1 and 4 pending and enabled, src 4 routed to INT0 -> VECTOR=0x8004; unroute src 4 -> VECTOR=0x8001.
- Hold WR0N low for 5 cycles with WDATA=0x007F to MASK -> exactly one commit; W1C and set colliding on the same cycle -> pending stays 1.
- Assert RESETN low mid-write with INTS[0] high -> all outputs clear; after release, PENDING bit0=1 and INT0=INT1=0.
